// File: rtl/lfsr_arb_ctrl.sv
// Round-robin burst arbiter feeding an LFSR word stream: gnt/dout_valid one cycle after req, dout holds while dout_ready is low.
// Optional 16-bit stall counter output when LFSR_ARB_STALL_CNT_EN is defined.
module lfsr_arb_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] POLY       = 8'b00001001,
  parameter int                    N_REQ      = 4,
  parameter int                    LEN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_WIDTH-1:0] burst_len,
  input  logic [DATA_WIDTH-1:0]      seed,
  input  logic                       seed_load,
  output logic [N_REQ-1:0]           gnt,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
`ifdef LFSR_ARB_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic                       done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DATA_WIDTH-1:0] LFSR_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] lfsr, lfsr_nxt;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [PW-1:0]         ptr, win, pick;
  logic                  pick_vld;
  logic                  hs;
  int                    idx;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && req[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = RUN;
      RUN:     if ((cnt == '0) || (hs && (cnt == LEN_WIDTH'(1)))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == RUN) gnt[win] = 1'b1;
  end

  assign dout_valid = (state == RUN) && (cnt != '0);
  assign hs         = dout_valid & dout_ready;
  assign busy       = (state == RUN) || (state == DONE);
  assign done       = (state == DONE);
  assign dout       = lfsr;
  assign lfsr_nxt   = {^(lfsr & POLY), lfsr[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= LFSR_ONE;
      ptr   <= '0;
      cnt   <= '0;
      win   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        // All-zero seed would lock the LFSR, so it loads as 1.
        if (seed_load) lfsr <= (seed == '0) ? LFSR_ONE : seed;
        if (pick_vld) begin
          win <= pick;
          cnt <= burst_len[int'(pick)*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      if (hs) begin
        lfsr <= lfsr_nxt;
        cnt  <= cnt - LEN_WIDTH'(1);
      end
      if (state == DONE) ptr <= (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
    end
  end

`ifdef LFSR_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && (|req)) begin
      stall_cnt <= '0;
    end else if (dout_valid && !dout_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_arb_ctrl.sv
// Directed bench for lfsr_arb_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_lfsr_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] burst_len = '0;
  logic [7:0]  seed = '0;
  logic        seed_load = 1'b0;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        busy;
  logic        done;
`ifdef LFSR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_arb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .burst_len  (burst_len),
    .seed       (seed),
    .seed_load  (seed_load),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
`ifdef LFSR_ARB_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; seed_load = 1'b0; dout_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({gnt, dout_valid, done, busy, dout} !== {4'b0000, 1'b0, 1'b0, 1'b0, 8'h01}) begin
      $display("FAIL reset_state: got gnt=%b v=%b done=%b busy=%b dout=%h, want 0000 0 0 0 01",
               gnt, dout_valid, done, busy, dout);
      n_fail++;
    end
    step();
    n_chk++;
    if ({gnt, dout_valid, done, busy} !== 7'b0) begin
      $display("FAIL idle_no_req: got gnt=%b v=%b done=%b busy=%b, want all 0", gnt, dout_valid, done, busy);
      n_fail++;
    end
`ifdef LFSR_ARB_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 16'd0) begin
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      n_fail++;
    end
`endif
  endtask

  task automatic test_seed_burst();
    logic [7:0] seq [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
    req = 4'b0001; burst_len = 32'h0000_0006; seed = 8'h01; seed_load = 1'b1;
    step();
    // burst must ignore req drop and length change once started
    seed_load = 1'b0; req = '0; burst_len = 32'h0000_00FF;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if ({gnt, dout_valid, done, busy, dout} !== {4'b0001, 1'b1, 1'b0, 1'b1, seq[i]}) begin
        $display("FAIL burst_word%0d: got gnt=%b v=%b done=%b dout=%h, want 0001 1 0 %h",
                 i, gnt, dout_valid, done, dout, seq[i]);
        n_fail++;
      end
      step();
    end
    n_chk++;
    if ({gnt, dout_valid, done, busy, dout} !== {4'b0000, 1'b0, 1'b1, 1'b1, 8'h84}) begin
      $display("FAIL burst_done: got gnt=%b v=%b done=%b busy=%b dout=%h, want 0000 0 1 1 84",
               gnt, dout_valid, done, busy, dout);
      n_fail++;
    end
    step();
    n_chk++;
    if ({gnt, dout_valid, done, busy} !== 7'b0) begin
      $display("FAIL burst_idle: got gnt=%b v=%b done=%b busy=%b, want all 0", gnt, dout_valid, done, busy);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] words [10] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h84, 8'h42, 8'h21, 8'h90};
    logic [3:0] eg;
    do_reset();
    req = 4'b1111; burst_len = 32'h0202_0202;
    for (int b = 0; b < 5; b++) begin
      eg = 4'b0001 << (b % 4);
      step();
      for (int w = 0; w < 2; w++) begin
        n_chk++;
        if ({gnt, dout_valid, done, dout} !== {eg, 1'b1, 1'b0, words[b*2+w]}) begin
          $display("FAIL rr_b%0d_w%0d: got gnt=%b v=%b done=%b dout=%h, want %b 1 0 %h",
                   b, w, gnt, dout_valid, done, dout, eg, words[b*2+w]);
          n_fail++;
        end
        step();
      end
      n_chk++;
      if ({gnt, dout_valid, done} !== {4'b0000, 1'b0, 1'b1}) begin
        $display("FAIL rr_done%0d: got gnt=%b v=%b done=%b, want 0000 0 1", b, gnt, dout_valid, done);
        n_fail++;
      end
      step();
      n_chk++;
      if ({done, busy} !== 2'b00) begin
        $display("FAIL rr_idle%0d: got done=%b busy=%b, want 0 0", b, done, busy);
        n_fail++;
      end
    end
    req = '0;
  endtask

  task automatic test_stall();
    logic [7:0] rest [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
    do_reset();
    req = 4'b0001; burst_len = 32'h0000_0005;
    step();
    req = '0;
    step();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({gnt, dout_valid, done, dout} !== {4'b0001, 1'b1, 1'b0, 8'h80}) begin
        $display("FAIL stall_hold%0d: got gnt=%b v=%b done=%b dout=%h, want 0001 1 0 80",
                 i, gnt, dout_valid, done, dout);
        n_fail++;
      end
    end
`ifdef LFSR_ARB_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 16'd3) begin
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
      n_fail++;
    end
`endif
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({done, dout_valid, dout} !== {1'b0, 1'b1, rest[i]}) begin
        $display("FAIL stall_resume%0d: got done=%b v=%b dout=%h, want 0 1 %h", i, done, dout_valid, dout, rest[i]);
        n_fail++;
      end
      step();
    end
    n_chk++;
    if ({done, dout_valid, dout} !== {1'b1, 1'b0, 8'h08}) begin
      $display("FAIL stall_done: got done=%b v=%b dout=%h, want 1 0 08", done, dout_valid, dout);
      n_fail++;
    end
    step();
  endtask

  task automatic test_zero_len();
    req = 4'b0010; burst_len = 32'h0000_0000;
    step();
    req = '0;
    n_chk++;
    if ({gnt, dout_valid, done, busy, dout} !== {4'b0010, 1'b0, 1'b0, 1'b1, 8'h08}) begin
      $display("FAIL zlen_gnt: got gnt=%b v=%b done=%b busy=%b dout=%h, want 0010 0 0 1 08",
               gnt, dout_valid, done, busy, dout);
      n_fail++;
    end
`ifdef LFSR_ARB_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 16'd0) begin
      $display("FAIL zlen_stall_clear: got %0d want 0", stall_cnt);
      n_fail++;
    end
`endif
    step();
    n_chk++;
    if ({gnt, dout_valid, done, dout} !== {4'b0000, 1'b0, 1'b1, 8'h08}) begin
      $display("FAIL zlen_done: got gnt=%b v=%b done=%b dout=%h, want 0000 0 1 08", gnt, dout_valid, done, dout);
      n_fail++;
    end
    step();
    // ptr is now 2: requesters 0 and 1 pending, search wraps to 0
    req = 4'b0011;
    step();
    req = '0;
    n_chk++;
    if ({gnt, dout_valid} !== {4'b0001, 1'b0}) begin
      $display("FAIL zlen_wrap: got gnt=%b v=%b, want 0001 0", gnt, dout_valid);
      n_fail++;
    end
    step();
    step();
  endtask

  task automatic test_seed();
    seed = 8'h00; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    n_chk++;
    if ({busy, dout} !== {1'b0, 8'h01}) begin
      $display("FAIL seed_zero: got busy=%b dout=%h, want 0 01", busy, dout);
      n_fail++;
    end
    req = 4'b0001; burst_len = 32'h0000_0004;
    step();
    req = '0;
    seed = 8'hAA; seed_load = 1'b1;
    step();
    n_chk++;
    if ({dout_valid, dout} !== {1'b1, 8'h80}) begin
      $display("FAIL seed_run1: got v=%b dout=%h, want 1 80", dout_valid, dout);
      n_fail++;
    end
    step();
    n_chk++;
    if (dout !== 8'h40) begin
      $display("FAIL seed_run2: got dout=%h, want 40", dout);
      n_fail++;
    end
    step();
    seed_load = 1'b0;
    n_chk++;
    if (dout !== 8'h20) begin
      $display("FAIL seed_run3: got dout=%h, want 20", dout);
      n_fail++;
    end
    step();
    n_chk++;
    if ({done, dout} !== {1'b1, 8'h10}) begin
      $display("FAIL seed_done: got done=%b dout=%h, want 1 10", done, dout);
      n_fail++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001; burst_len = 32'h0000_000A;
    step();
    n_chk++;
    if ({gnt, dout_valid, dout} !== {4'b0001, 1'b1, 8'h10}) begin
      $display("FAIL rmid_start: got gnt=%b v=%b dout=%h, want 0001 1 10", gnt, dout_valid, dout);
      n_fail++;
    end
    step();
    step();
    n_chk++;
    if (dout !== 8'h84) begin
      $display("FAIL rmid_word3: got dout=%h, want 84", dout);
      n_fail++;
    end
    rst = 1'b1; req = '0;
    step();
    n_chk++;
    if ({gnt, dout_valid, done, busy, dout} !== {4'b0000, 1'b0, 1'b0, 1'b0, 8'h01}) begin
      $display("FAIL rmid_abort: got gnt=%b v=%b done=%b busy=%b dout=%h, want 0000 0 0 0 01",
               gnt, dout_valid, done, busy, dout);
      n_fail++;
    end
    rst = 1'b0;
    step();
    n_chk++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL rmid_no_done: got done=%b busy=%b, want 0 0", done, busy);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_seed_burst();
    test_round_robin();
    test_stall();
    test_zero_len();
    test_seed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_arb_ctrl.md
LFSR_ARB_CTRL -- requirements
Module: lfsr_arb_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the LFSR word width.
REQ-002 Parameter POLY, default 8'b00001001, SHALL set the feedback tap mask, DATA_WIDTH bits.
REQ-003 Parameter N_REQ, default 4, SHALL set the number of requesters.
REQ-004 Parameter LEN_WIDTH, default 8, SHALL set the burst-length field width.
REQ-005 clk  in  1  SHALL be the clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  SHALL be the synchronous active-high reset.
REQ-007 req  in  N_REQ  SHALL carry per-requester burst requests, level-sensitive.
REQ-008 burst_len  in  N_REQ*LEN_WIDTH  SHALL carry packed per-requester lengths; requester i uses slice [i*LEN_WIDTH +: LEN_WIDTH].
REQ-009 seed  in  DATA_WIDTH  SHALL carry the new LFSR state.
REQ-010 seed_load  in  1  SHALL be a single-cycle strobe that loads seed.
REQ-011 gnt  out  N_REQ  SHALL be the one-hot grant, all-zero when idle.
REQ-012 dout  out  DATA_WIDTH  SHALL present the current LFSR state.
REQ-013 dout_valid  out  1  SHALL qualify dout.
REQ-014 dout_ready  in  1  SHALL be the downstream ready signal.
REQ-015 busy  out  1  SHALL be high in RUN and DONE.
REQ-016 done  out  1  SHALL pulse for one cycle at burst end.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE SHALL move to RUN when req is non-zero, selecting the round-robin winner: the first set bit at or after pointer ptr, wrapping at N_REQ.
REQ-019 On entering RUN, gnt SHALL assert one-cycle after the req sample; dout_valid SHALL assert in the same cycle; the winner's burst_len SHALL be latched into a down-counter.
REQ-020 A latched length of 0 SHALL go directly to DONE with no dout_valid.
REQ-021 LFSR step SHALL be: next = {^(lfsr & POLY), lfsr[DATA_WIDTH-1:1]}.
REQ-022 The LFSR SHALL advance only on a handshake (dout_valid & dout_ready); the counter SHALL decrement on the same handshake.
REQ-023 When dout_ready is low, dout SHALL hold stable.
REQ-024 RUN SHALL move to DONE on the handshake that takes the counter from 1 to 0.
REQ-025 In DONE, done SHALL be 1 for one cycle with gnt and dout_valid at 0; ptr SHALL become winner+1 mod N_REQ; the next state SHALL be IDLE.
REQ-026 Deasserting req or changing burst_len mid-burst SHALL NOT affect the current burst.
REQ-027 seed_load SHALL be honoured only in IDLE and ignored in RUN/DONE.
REQ-028 A seed of all-zeros SHALL load as 1 (lock-up avoidance).
REQ-029 If seed_load and req are both active in IDLE, the seed SHALL load and the burst SHALL start from that seed.
REQ-030 The LFSR state SHALL persist across bursts; it is not reseeded per grant.

Reset
REQ-031 rst SHALL force state to IDLE, lfsr to 1, ptr to 0, and the counter to 0.
REQ-032 rst SHALL force gnt, dout_valid, busy and done to 0.
REQ-033 rst mid-burst SHALL abort the burst with no done pulse.

Configuration
REQ-034 Macro LFSR_ARB_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits).
REQ-035 stall_cnt SHALL increment each cycle in which dout_valid & !dout_ready, saturate at 0xFFFF, clear on rst, and clear on entry to RUN.
REQ-036 When LFSR_ARB_STALL_CNT_EN is undefined, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset, seed_load with 8'h01 in IDLE, req=4'b0001, len0=6, dout_ready=1 -> dout sequence 01,80,40,20,10,08, then done pulse, then IDLE.
REQ-038 req=4'b1111 held, all lengths 2 -> grants in order 0,1,2,3,0; done pulse between each.
REQ-039 dout_ready held low for 3 cycles mid-burst -> dout stable, counter unchanged, stall_cnt=3 when the macro is defined.
REQ-040 len=0 for the winner -> no dout_valid, done on the cycle after gnt, ptr advances.
REQ-041 seed=0 loaded -> dout=8'h01; seed_load during RUN -> ignored, sequence unbroken.
REQ-042 rst asserted at the 3rd word of a 10-word burst -> next cycle gnt=0, dout_valid=0, dout=01, no done pulse.
